// File: rtl/axi_lite_cfg_arbiter_if.sv
// AXI4-Lite control-port bundle between the config arbiter (master) and a register-bank slave.
interface axi_lite_cfg_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 4
);
   logic [AW-1:0]   awaddr;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_cfg_arbiter.sv
// Two-requester round-robin AXI4-Lite master, one transaction in flight.
// Optional watchdog flag enabled by defining AXI_TIMEOUT_EN.
module axi_lite_cfg_arbiter #(
   parameter int C_M00_AXI_DATA_WIDTH = 32,
   parameter int C_M00_AXI_ADDR_WIDTH = 4,
   parameter int TIMEOUT_CYCLES       = 16
) (
   input  logic                                m00_axi_aclk,
   input  logic                                m00_axi_aresetn,
   input  logic [1:0]                          req_valid,
   output logic [1:0]                          req_ready,
   input  logic [1:0]                          req_we,
   input  logic [2*C_M00_AXI_ADDR_WIDTH-1:0]   req_addr,
   input  logic [2*C_M00_AXI_DATA_WIDTH-1:0]   req_wdata,
   output logic [1:0]                          rsp_valid,
   output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                          rsp_resp,
   axi_lite_cfg_arbiter_if.master              m00_axi,
   output logic                                timeout_o
);
   localparam int DW = C_M00_AXI_DATA_WIDTH;
   localparam int AW = C_M00_AXI_ADDR_WIDTH;

   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_e;

   state_e        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          last_q, last_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [1:0]    resp_q, resp_d;
   logic          awvalid_q, awvalid_d;
   logic          wvalid_q, wvalid_d;
   logic          arvalid_q, arvalid_d;
   logic          sel;

   // Contention goes to whoever was not served last; a lone request wins outright.
   assign sel = (req_valid == 2'b11) ? ~last_q : req_valid[1];

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      req_ready = 2'b00;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready = sel ? 2'b10 : 2'b01;
               gnt_d     = sel;
               addr_d    = sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
               rdata_d   = '0;
               if (sel ? req_we[1] : req_we[0]) begin
                  wdata_d   = sel ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WADDR;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RADDR;
               end
            end
         end
         WADDR: begin
            if (awvalid_q && m00_axi.awready) awvalid_d = 1'b0;
            if (wvalid_q && m00_axi.wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d)      state_d   = WRESP;
         end
         WRESP: begin
            if (m00_axi.bvalid) begin
               resp_d  = m00_axi.bresp;
               state_d = RESP;
            end
         end
         RADDR: begin
            if (m00_axi.arready) begin
               arvalid_d = 1'b0;
               state_d   = RDATA;
            end
         end
         RDATA: begin
            if (m00_axi.rvalid) begin
               rdata_d = m00_axi.rdata;
               resp_d  = m00_axi.rresp;
               state_d = RESP;
            end
         end
         RESP: begin
            last_d  = gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
      if (!m00_axi_aresetn) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= 2'b00;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
      end
   end

   assign m00_axi.awaddr  = addr_q;
   assign m00_axi.awvalid = awvalid_q;
   assign m00_axi.wdata   = wdata_q;
   assign m00_axi.wstrb   = '1;
   assign m00_axi.wvalid  = wvalid_q;
   assign m00_axi.bready  = (state_q == WRESP);
   assign m00_axi.araddr  = addr_q;
   assign m00_axi.arvalid = arvalid_q;
   assign m00_axi.rready  = (state_q == RDATA);

   assign rsp_valid = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
   assign rsp_resp  = (state_q == RESP) ? resp_q : 2'b00;

`ifdef AXI_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;
   logic          busy;

   assign busy = (state_q == WADDR) || (state_q == WRESP) ||
                 (state_q == RADDR) || (state_q == RDATA);

   // Counter saturates at the limit; the flag only observes, never aborts.
   always_comb begin
      cnt_d = cnt_q;
      to_d  = to_q;
      if (state_q == IDLE) cnt_d = '0;
      else if (busy && (cnt_q != CW'(TIMEOUT_CYCLES))) cnt_d = cnt_q + 1'b1;
      if (busy && (cnt_d == CW'(TIMEOUT_CYCLES))) to_d = 1'b1;
   end

   always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
      if (!m00_axi_aresetn) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end

   assign timeout_o = to_q;
`else
   assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_cfg_arbiter.sv
// Self-checking bench: table-driven commands against a delay-configurable AXI-Lite slave, scoreboarded completions.
module tb_axi_lite_cfg_arbiter;
   localparam int DW = 32;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_ready;
   logic [1:0]      req_we = '0;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*DW-1:0] req_wdata = '0;
   logic [1:0]      rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_resp;
   logic            timeout_o;

   axi_lite_cfg_arbiter_if #(.DW(DW), .AW(AW)) axi ();

   axi_lite_cfg_arbiter #(
      .C_M00_AXI_DATA_WIDTH(DW), .C_M00_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)
   ) dut (
      .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m00_axi(axi.master), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- slave model ----------------
   int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
   logic [DW-1:0] cfg_rdata = '0;
   logic [1:0]  cfg_resp = 2'b00;
   int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   int          aw_hi, w_hi, ar_hi, b_hs_n;
   logic        aw_seen, w_seen, b_pend, r_pend;
   logic [AW-1:0] rd_addr, last_awaddr;
   logic [DW-1:0] last_wdata;
   wire aw_hs = axi.awvalid && axi.awready;
   wire w_hs  = axi.wvalid && axi.wready;
   wire b_hs  = axi.bvalid && axi.bready;
   wire ar_hs = axi.arvalid && axi.arready;
   wire r_hs  = axi.rvalid && axi.rready;

   assign axi.awready = axi.awvalid && (aw_cnt >= cfg_aw_dly);
   assign axi.wready  = axi.wvalid && (w_cnt >= cfg_w_dly);
   assign axi.arready = axi.arvalid && (ar_cnt >= cfg_ar_dly);
   assign axi.bvalid  = b_pend && (b_cnt >= cfg_b_dly);
   assign axi.bresp   = axi.bvalid ? cfg_resp : 2'b00;
   assign axi.rvalid  = r_pend && (r_cnt >= cfg_r_dly);
   assign axi.rdata   = axi.rvalid ? (cfg_rdata ^ DW'(rd_addr)) : '0;
   assign axi.rresp   = axi.rvalid ? cfg_resp : 2'b00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
         aw_hi <= 0; w_hi <= 0; ar_hi <= 0; b_hs_n <= 0;
         aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         rd_addr <= '0; last_awaddr <= '0; last_wdata <= '0;
      end else begin
         aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
         ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
         if (axi.awvalid) aw_hi <= aw_hi + 1;
         if (axi.wvalid)  w_hi <= w_hi + 1;
         if (axi.arvalid) ar_hi <= ar_hi + 1;
         if (aw_hs) last_awaddr <= axi.awaddr;
         if (w_hs)  last_wdata <= axi.wdata;
         if (!b_pend && (aw_seen || aw_hs) && (w_seen || w_hs)) begin
            b_pend <= 1'b1; b_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
         end else begin
            if (aw_hs) aw_seen <= 1'b1;
            if (w_hs)  w_seen <= 1'b1;
         end
         if (b_pend) begin
            if (b_hs) begin b_pend <= 1'b0; b_hs_n <= b_hs_n + 1; end
            else if (!axi.bvalid) b_cnt <= b_cnt + 1;
         end
         if (ar_hs) begin r_pend <= 1'b1; r_cnt <= 0; rd_addr <= axi.araddr; end
         else if (r_pend) begin
            if (r_hs) r_pend <= 1'b0;
            else if (!axi.rvalid) r_cnt <= r_cnt + 1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct { logic id; logic [DW-1:0] rdata; logic [1:0] resp; } exp_t;
   exp_t sb[$];
   int   last_rsp_cyc = 0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid != 2'b00) begin
            last_rsp_cyc = cyc;
            check("rsp_onehot", 64'($countones(rsp_valid)), 64'd1);
            if (sb.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            else begin
               e = sb.pop_front();
               check("rsp_id", 64'(rsp_valid), e.id ? 64'd2 : 64'd1);
               check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
            end
         end
      end
   end

   task automatic push(input logic id, input logic [DW-1:0] rd, input logic [1:0] rs);
      exp_t e;
      e.id = id; e.rdata = rd; e.resp = rs;
      sb.push_back(e);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("rsp_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   task automatic send(input int id, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, output int acc);
      bit ok = 0;
      acc = 0;
      @(negedge clk);
      req_valid[id] = 1'b1;
      req_we[id] = we;
      req_addr[id*AW +: AW] = a;
      req_wdata[id*DW +: DW] = wd;
      for (int i = 0; i < 60 && !ok; i++) begin
         #1;
         if (req_ready[id]) begin ok = 1; acc = cyc; end
         else @(negedge clk);
      end
      if (!ok) check("req_accept", 64'd0, 64'd1);
      @(posedge clk);
      #1 req_valid[id] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      int id; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;
      int aw_dly, w_dly, b_dly, ar_dly, r_dly;
      logic [DW-1:0] sl_rdata; logic [1:0] sl_resp;
      logic [DW-1:0] exp_rdata; logic [1:0] exp_resp; int exp_lat;
   } vec_t;

   task automatic run_vec(input vec_t v);
      int acc, aw0, w0, ar0, b0;
      cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly;
      cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly;
      cfg_rdata = v.sl_rdata; cfg_resp = v.sl_resp;
      aw0 = aw_hi; w0 = w_hi; ar0 = ar_hi; b0 = b_hs_n;
      push(v.id[0], v.exp_rdata, v.exp_resp);
      send(v.id, v.we, v.addr, v.wdata, acc);
      wait_done(100);
      check("latency", 64'(last_rsp_cyc - acc), 64'(v.exp_lat));
      if (v.we) begin
         check("awvalid_cycles", 64'(aw_hi - aw0), 64'(v.aw_dly + 1));
         check("wvalid_cycles", 64'(w_hi - w0), 64'(v.w_dly + 1));
         check("b_handshakes", 64'(b_hs_n - b0), 64'd1);
         check("awaddr", 64'(last_awaddr), 64'(v.addr));
         check("wdata", 64'(last_wdata), 64'(v.wdata));
      end else begin
         check("arvalid_cycles", 64'(ar_hi - ar0), 64'(v.ar_dly + 1));
      end
   endtask

   vec_t vecs[6];

   initial begin
      int acc, k;
      logic [1:0] rr_exp [4];
      vecs[0] = '{0, 1'b1, 4'h0, 32'h1,        0,0,0,0,0, 32'h0,        2'b00, 32'h0,        2'b00, 3};
      vecs[1] = '{1, 1'b0, 4'h4, 32'h0,        0,0,0,0,2, 32'h2E,       2'b00, 32'h2A,       2'b00, 5};
      vecs[2] = '{0, 1'b0, 4'hF, 32'h0,        0,0,0,0,0, 32'h12345670, 2'b00, 32'h1234567F, 2'b00, 3};
      vecs[3] = '{1, 1'b1, 4'hA, 32'hDEADBEEF, 3,0,0,0,0, 32'h0,        2'b10, 32'h0,        2'b10, 6};
      vecs[4] = '{1, 1'b0, 4'h3, 32'h0,        0,0,0,1,0, 32'h0,        2'b11, 32'h3,        2'b11, 4};
      vecs[5] = '{0, 1'b1, 4'h5, 32'h55AA,     0,2,1,0,0, 32'h0,        2'b01, 32'h0,        2'b01, 6};

      // reset state
      #12;
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_axi_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'd0);
      check("rst_wstrb", 64'(axi.wstrb), 64'hF);
      check("rst_timeout", 64'(timeout_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1 check("idle_req_ready", 64'(req_ready), 64'd0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // round robin from reset with both requesters always valid
      do_reset();
      cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
      cfg_rdata = 32'h100; cfg_resp = 2'b00;
      rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
      @(negedge clk);
      req_we = 2'b00;
      req_addr = {4'h2, 4'h1};
      req_valid = 2'b11;
      k = 0;
      for (int c = 0; c < 80 && k < 4; c++) begin
         #1;
         if (req_ready != 2'b00) begin
            check("rr_grant", 64'(req_ready), 64'(rr_exp[k]));
            push(req_ready[1], req_ready[1] ? 32'h102 : 32'h101, 2'b00);
            k++;
         end
         @(posedge clk);
         #1 if (k == 4) req_valid = 2'b00;
         @(negedge clk);
      end
      req_valid = 2'b00;
      check("rr_count", 64'(k), 64'd4);
      wait_done(100);

      // reset while the read waits in the data phase
      cfg_r_dly = 20; cfg_rdata = 32'h0;
      send(0, 1'b0, 4'h6, 32'h0, acc);
      repeat (2) @(negedge clk);
      check("pre_rst_rready", 64'(axi.rready), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_outputs", 64'({rsp_valid, req_ready, axi.awvalid, axi.wvalid,
                                    axi.arvalid, axi.bready, axi.rready, timeout_o}), 64'd0);
      check("mid_rst_data", 64'({rsp_rdata, rsp_resp}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      run_vec('{1, 1'b0, 4'h9, 32'h0, 0,0,0,0,1, 32'hA0, 2'b00, 32'hA9, 2'b00, 4});

`ifdef AXI_TIMEOUT_EN
      do_reset();
      cfg_ar_dly = 20; cfg_r_dly = 0; cfg_rdata = 32'h0; cfg_resp = 2'b00;
      push(1'b0, 32'h7, 2'b00);
      send(0, 1'b0, 4'h7, 32'h0, acc);
      repeat (13) @(negedge clk);
      check("timeout_early", 64'(timeout_o), 64'd0);
      repeat (4) @(negedge clk);
      check("timeout_set", 64'(timeout_o), 64'd1);
      wait_done(100);
      repeat (5) @(negedge clk);
      check("timeout_sticky", 64'(timeout_o), 64'd1);
      do_reset();
      #1 check("timeout_cleared", 64'(timeout_o), 64'd0);
`else
      check("timeout_tied", 64'(timeout_o), 64'd0);
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
